// File: rtl/unidad_multiciclo.sv
// ---------------------------------------------------------------------------
// unidad_multiciclo
//   Multi-cycle MIPS control unit. A Moore FSM walks each instruction through
//   FETCH / DECODE / EXEC / MEM / WB and drives the datapath control lines.
//   Memory accesses (FETCH, MEMRD, MEMWR) wait on a variable-latency memory
//   through mem_ready. A wait counter aborts to ERROR if the memory stalls too
//   long. An illegal opcode also sends the unit to ERROR, which is sticky
//   until reset.
//
// Parameters
//   ALOP_W       width of alop (encodings zero-extended)
//   MEM_TIMEOUT  consecutive not-ready cycles tolerated; 0 disables timeout
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   op         opcode from the instruction register
//   mem_ready  memory finishes the current access this cycle
//   regdst     1 = write rd, 0 = write rt
//   branch     PC conditional write (beq)
//   jump       PC load from jump target
//   memread    memory read request
//   memreg     writeback data from memory data register
//   memwrite   memory write request
//   alusrc     ALU B operand is the sign-extended immediate
//   regwrite   register file write enable
//   alop       000 add, 001 sub, 111 R-type
//   pcwrite    PC <= PC+4 (fetch completes)
//   irwrite    instruction register load
//   iord       0 = address from PC, 1 = address from ALU out
//   err        sticky error flag
//   state      current state code (debug)
// ---------------------------------------------------------------------------
module unidad_multiciclo #(
  parameter int ALOP_W      = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        op,
  input  logic              mem_ready,
  output logic              regdst,
  output logic              branch,
  output logic              jump,
  output logic              memread,
  output logic              memreg,
  output logic              memwrite,
  output logic              alusrc,
  output logic              regwrite,
  output logic [ALOP_W-1:0] alop,
  output logic              pcwrite,
  output logic              irwrite,
  output logic              iord,
  output logic              err,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_ADDR   = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IWB    = 4'd10,
    S_ERROR  = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [ALOP_W-1:0] ALOP_ADD = ALOP_W'(3'b000);
  localparam logic [ALOP_W-1:0] ALOP_SUB = ALOP_W'(3'b001);
  localparam logic [ALOP_W-1:0] ALOP_R   = ALOP_W'(3'b111);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
  // The counter holds the number of not-ready cycles already spent; when it
  // sits at MEM_TIMEOUT-1 and the memory is still not ready, this cycle is
  // the MEM_TIMEOUT-th wait and the unit gives up.
  localparam logic [CNT_W-1:0] WAIT_LAST =
    (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_wait;
  logic [CNT_W-1:0] w_wait_next;
  logic             w_mem_state;
  logic             w_timeout;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                       (r_state == S_MEMWR);
  // mem_ready in the same cycle overrides the timeout
  assign w_timeout   = TIMEOUT_EN && w_mem_state && !mem_ready &&
                       (r_wait == WAIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
    end
  end

  // Next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)      w_state_next = S_DECODE;
        else if (w_timeout) w_state_next = S_ERROR;
      end
      S_DECODE: begin
        case (op)
          OP_R:                   w_state_next = S_EXEC;
          OP_LW, OP_SW, OP_ADDI:  w_state_next = S_ADDR;
          OP_BEQ:                 w_state_next = S_BRANCH;
          OP_J:                   w_state_next = S_JUMP;
          default:                w_state_next = S_ERROR;
        endcase
      end
      S_ADDR: begin
        // op is expected stable since DECODE; anything else is treated as illegal
        case (op)
          OP_LW:   w_state_next = S_MEMRD;
          OP_SW:   w_state_next = S_MEMWR;
          OP_ADDI: w_state_next = S_IWB;
          default: w_state_next = S_ERROR;
        endcase
      end
      S_MEMRD: begin
        if (mem_ready)      w_state_next = S_MEMWB;
        else if (w_timeout) w_state_next = S_ERROR;
      end
      S_MEMWR: begin
        if (mem_ready)      w_state_next = S_FETCH;
        else if (w_timeout) w_state_next = S_ERROR;
      end
      S_MEMWB:  w_state_next = S_FETCH;
      S_EXEC:   w_state_next = S_RWB;
      S_RWB:    w_state_next = S_FETCH;
      S_BRANCH: w_state_next = S_FETCH;
      S_JUMP:   w_state_next = S_FETCH;
      S_IWB:    w_state_next = S_FETCH;
      S_ERROR:  w_state_next = S_ERROR;
      default:  w_state_next = S_ERROR;   // unused codes 11..14
    endcase
  end

  // Wait counter: counts only while parked in a memory state with the memory
  // not ready; leaving or re-entering a memory state starts it from zero.
  always_comb begin
    w_wait_next = '0;
    if (w_mem_state && !mem_ready && (w_state_next == r_state))
      w_wait_next = r_wait + CNT_W'(1);
  end

  // Moore outputs
  always_comb begin
    regdst   = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    memread  = 1'b0;
    memreg   = 1'b0;
    memwrite = 1'b0;
    alusrc   = 1'b0;
    regwrite = 1'b0;
    alop     = ALOP_ADD;
    pcwrite  = 1'b0;
    irwrite  = 1'b0;
    iord     = 1'b0;
    err      = 1'b0;
    case (r_state)
      S_FETCH: begin
        memread = 1'b1;
        pcwrite = mem_ready;
        irwrite = mem_ready;
      end
      S_ADDR: begin
        alusrc = 1'b1;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memreg   = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_EXEC:   alop = ALOP_R;
      S_RWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        branch = 1'b1;
        alop   = ALOP_SUB;
      end
      S_JUMP:   jump = 1'b1;
      S_IWB:    regwrite = 1'b1;
      S_ERROR:  err = 1'b1;
      default:  ;
    endcase
    // Architectural writes are suppressed while reset is held
    if (reset) begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_unidad_multiciclo.sv
module tb_unidad_multiciclo;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b1;
  logic       regdst, branch, jump, memread, memreg, memwrite, alusrc;
  logic       regwrite, pcwrite, irwrite, iord, err;
  logic [2:0] alop;
  logic [3:0] state;

  unidad_multiciclo #(.ALOP_W(3), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .regdst(regdst), .branch(branch), .jump(jump), .memread(memread),
    .memreg(memreg), .memwrite(memwrite), .alusrc(alusrc),
    .regwrite(regwrite), .alop(alop), .pcwrite(pcwrite), .irwrite(irwrite),
    .iord(iord), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, J = 6'b000010;

  int ntests = 0;
  int nfail  = 0;
  bit live   = 0;

  // ---------------- behavioural model ----------------
  // Instruction-level view: at the end of a fetch, the remaining path of
  // states for the opcode is queued; memory states hold while not ready.
  int         m_state = 0;
  int         m_wait = 0;
  int         m_q[$];
  int         m_cycles = 0;
  int         m_last_cycles = 0;
  logic [5:0] m_op = 6'd0;

  task automatic model_reset();
    m_state = 0;
    m_wait = 0;
    m_q.delete();
    m_cycles = 0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
      return;
    end
    if (m_state == 15) return;
    m_cycles++;
    if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
      m_wait++;
      if (m_wait >= TO) begin
        $display("[TB] op=%b memory timeout in state %0d", m_op, m_state);
        m_state = 15;
        m_wait = 0;
        m_q.delete();
      end
      return;
    end
    m_wait = 0;
    if (m_state == 0) begin
      m_op = op;
      m_q.push_back(1);
      case (op)
        R:    begin m_q.push_back(6); m_q.push_back(7); end
        LW:   begin m_q.push_back(2); m_q.push_back(3); m_q.push_back(4); end
        SW:   begin m_q.push_back(2); m_q.push_back(5); end
        ADDI: begin m_q.push_back(2); m_q.push_back(10); end
        BEQ:  m_q.push_back(8);
        J:    m_q.push_back(9);
        default: m_q.push_back(15);
      endcase
    end
    if (m_q.size() > 0) begin
      m_state = m_q.pop_front();
      if (m_state == 15) $display("[TB] op=%b illegal opcode", m_op);
    end else begin
      m_last_cycles = m_cycles;
      $display("[TB] op=%b done in %0d cycles", m_op, m_cycles);
      m_cycles = 0;
      m_state = 0;
    end
  endtask

  // Output table: {regdst,branch,jump,memread,memreg,memwrite,alusrc,
  //                regwrite,pcwrite,irwrite,iord,err}
  function automatic logic [11:0] exp_flags(input int st, input logic mr, input logic rst);
    logic [11:0] f;
    f = '0;
    case (st)
      0:  begin f[8] = 1'b1; f[3] = mr & ~rst; f[2] = mr & ~rst; end
      2:  f[5] = 1'b1;
      3:  begin f[8] = 1'b1; f[1] = 1'b1; end
      4:  begin f[4] = 1'b1; f[7] = 1'b1; end
      5:  begin f[6] = 1'b1; f[1] = 1'b1; end
      7:  begin f[4] = 1'b1; f[11] = 1'b1; end
      8:  f[10] = 1'b1;
      9:  f[9] = 1'b1;
      10: f[4] = 1'b1;
      15: f[0] = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

  function automatic logic [2:0] exp_alop(input int st);
    if (st == 6) return 3'b111;
    if (st == 8) return 3'b001;
    return 3'b000;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (live) begin
      logic [11:0] act_f, ex_f;
      act_f = {regdst, branch, jump, memread, memreg, memwrite, alusrc,
               regwrite, pcwrite, irwrite, iord, err};
      ex_f  = exp_flags(m_state, mem_ready, reset);
      ntests++;
      if (state !== 4'(m_state)) begin
        nfail++;
        $display("FAIL cyc_state t=%0t got=%0d expected=%0d", $time, state, m_state);
      end
      ntests++;
      if (act_f !== ex_f) begin
        nfail++;
        $display("FAIL cyc_flags t=%0t state=%0d got=%b expected=%b", $time, m_state, act_f, ex_f);
      end
      ntests++;
      if (alop !== exp_alop(m_state)) begin
        nfail++;
        $display("FAIL cyc_alop t=%0t state=%0d got=%b expected=%b", $time, m_state, alop, exp_alop(m_state));
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic lit(input logic [31:0] act, input logic [31:0] exp, input string nm);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic cyc(input logic [5:0] o, input logic mr);
    tick();
    reset = 1'b0;
    op = o;
    mem_ready = mr;
    #1;
  endtask

  task automatic reset_cycle();
    tick();
    reset = 1'b1;
    model_reset();
    #1;
  endtask

  // Runs n cycles from FETCH; state i expected in sts[4*i+:4], mem_ready in mrs[i]
  task automatic run_instr(input logic [5:0] o, input int n, input logic [31:0] sts,
                           input logic [7:0] mrs, input string nm);
    for (int i = 0; i < n; i++) begin
      cyc(o, mrs[i]);
      lit(32'(state), 32'(sts[4*i +: 4]), nm);
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] tbl [6];
    tbl = '{R, LW, SW, ADDI, BEQ, J};
    if ($urandom_range(0, 9) == 0) return 6'($urandom);
    return tbl[$urandom_range(0, 5)];
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int err_run;
    // Reset held with memory ready
    reset = 1'b1; op = R; mem_ready = 1'b1;
    tick(); live = 1;
    reset_cycle();
    reset_cycle();
    lit(32'(state), 0, "rst_state");
    lit(32'(memread), 1, "rst_memread");
    lit(32'(pcwrite), 0, "rst_pcwrite");
    lit(32'(irwrite), 0, "rst_irwrite");
    lit(32'(err), 0, "rst_err");

    // R-type, zero wait
    run_instr(R, 3, 32'h610, 8'h07, "r_seq");
    lit(32'(alop), 32'h7, "r_exec_alop");
    cyc(R, 1'b1);
    lit(32'(state), 7, "r_rwb_state");
    lit(32'(regwrite), 1, "r_rwb_regwrite");
    lit(32'(regdst), 1, "r_rwb_regdst");

    // lw with three not-ready cycles in MEMRD
    run_instr(LW, 8, 32'h43333210, 8'hC7, "lw_seq");
    lit(32'(memreg), 1, "lw_memreg");
    lit(32'(regwrite), 1, "lw_regwrite");
    lit(32'(m_last_cycles), 4, "model_r_cycles");

    // sw, beq, j
    run_instr(SW, 4, 32'h5210, 8'h0F, "sw_seq");
    lit(32'(memwrite), 1, "sw_memwrite");
    lit(32'(iord), 1, "sw_iord");
    lit(32'(regwrite), 0, "sw_no_regwrite");
    lit(32'(m_last_cycles), 8, "model_lw_cycles");
    run_instr(BEQ, 3, 32'h810, 8'h07, "beq_seq");
    lit(32'(branch), 1, "beq_branch");
    lit(32'(alop), 1, "beq_alop");
    lit(32'(regwrite), 0, "beq_no_regwrite");
    lit(32'(m_last_cycles), 4, "model_sw_cycles");
    run_instr(J, 3, 32'h910, 8'h07, "j_seq");
    lit(32'(jump), 1, "j_jump");
    lit(32'(regwrite), 0, "j_no_regwrite");
    lit(32'(m_last_cycles), 3, "model_beq_cycles");

    // Illegal opcode: sticky error, cleared by reset
    run_instr(6'h3F, 2, 32'h10, 8'h03, "ill_seq");
    lit(32'(m_last_cycles), 3, "model_j_cycles");
    for (int i = 0; i < 20; i++) begin
      cyc(6'h3F, 1'($urandom));
      lit(32'(err), 1, "ill_err_sticky");
    end
    reset_cycle();
    lit(32'(state), 0, "ill_reset_state");
    lit(32'(err), 0, "ill_reset_err");

    // Fetch timeout: four not-ready cycles -> ERROR
    for (int i = 0; i < 4; i++) begin
      cyc(R, 1'b0);
      lit(32'(state), 0, "to_wait_state");
    end
    cyc(R, 1'b0);
    lit(32'(state), 15, "to_error_state");
    lit(32'(err), 1, "to_error_err");
    reset_cycle();
    // Ready on the fourth cycle wins over the timeout
    for (int i = 0; i < 3; i++) cyc(R, 1'b0);
    cyc(R, 1'b1);
    lit(32'(state), 0, "to_race_fetch");
    lit(32'(pcwrite), 1, "to_race_pcwrite");
    cyc(R, 1'b1);
    lit(32'(state), 1, "to_race_decode");
    lit(32'(err), 0, "to_race_err");

    // Randomized traffic with occasional resets
    err_run = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (m_state == 15) err_run++;
      else err_run = 0;
      if (err_run > 3 || $urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        model_reset();
        err_run = 0;
      end else begin
        reset = 1'b0;
        if (m_state == 0) op = pick_op();
        mem_ready = ($urandom_range(0, 99) < 65);
      end
      #1;
    end
    tick();
    live = 0;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
